layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
- REQ-001 SHALL have parameter STATE_DATAWIDTH, default 4, the width of State.
- REQ-002 SHALL have parameters RESET=0, IDLE=1, CONV1_1_STATE=2, CONV1_2_STATE=3, AVG_POOL1=4, CONV2_1_STATE=5, CONV2_2_STATE=6, AVG_POOL2=7, CONV3_1_STATE=8, CONV3_2_STATE=9, AVG_POOL3=10, FC_STATE=11, JUDGE=12; these are the state encodings.
- REQ-003 SHALL have parameter GUARD_CYCLES, default 4: idle cycles between a State change and stage_start.
- REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1048575: maximum cycles from stage_start to stage_done.
- REQ-005 clk  input  1  single clock; all logic on its rising edge.
- REQ-006 rst  input  1  synchronous, active-high reset.
- REQ-007 start  input  1  level request to process one frame.
- REQ-008 PS_BRAM_busy  input  1  high while the PS is still writing the input BRAM.
- REQ-009 stage_done  input  1  one-cycle pulse from the active compute stage.
- REQ-010 judge_result  input  1  detection decision; valid only when stage_done is high in JUDGE.
- REQ-011 State  output  STATE_DATAWIDTH  current state; drives the clock switch and the datapath muxes.
- REQ-012 stage_start  output  1  one-cycle pulse that launches the stage named by State.
- REQ-013 busy  output  1  high whenever State is not IDLE and not RESET.
- REQ-014 frame_done  output  1  one-cycle pulse when a frame completes.
- REQ-015 human_detected  output  1  registered result of the last completed frame.
- REQ-016 timeout_err  output  1  one-cycle pulse when a stage times out.

Function
- REQ-017 All outputs SHALL be registered.
- REQ-018 State SHALL change only on a clk edge, never combinationally, so the downstream clock mux sees a glitch-free select.
- REQ-019 RESET SHALL advance to IDLE unconditionally after one cycle.
- REQ-020 IDLE SHALL advance to CONV1_1_STATE in the cycle after a sample with start=1 and PS_BRAM_busy=0; otherwise it SHALL stay in IDLE.
- REQ-021 The compute order SHALL be CONV1_1, CONV1_2, AVG_POOL1, CONV2_1, CONV2_2, AVG_POOL2, CONV3_1, CONV3_2, AVG_POOL3, FC_STATE, JUDGE, then IDLE.
- REQ-022 On entry to each compute state, a guard counter SHALL load GUARD_CYCLES-1 and decrement to 0.
- REQ-023 stage_start SHALL pulse in the cycle after the guard counter reaches 0, exactly once per state entry.
- REQ-024 With GUARD_CYCLES=0, stage_start SHALL pulse in the first cycle after entry.
- REQ-025 After stage_start, a stage_done pulse SHALL advance State on the next edge; the guard counter reloads for the new state.
- REQ-026 stage_done SHALL be ignored before stage_start has been issued in the current state, and ignored in IDLE and RESET.
- REQ-027 When stage_done is high in JUDGE: human_detected <= judge_result, frame_done pulses, and State <= IDLE, all on the same edge.
- REQ-028 A timeout counter SHALL be 20 bits wide, clear on stage_start, and increment each cycle while awaiting stage_done.
- REQ-029 When the timeout counter reaches TIMEOUT_CYCLES without stage_done: timeout_err pulses, State <= IDLE, frame_done stays 0, human_detected is unchanged.
- REQ-030 If stage_done arrives in the same cycle the timeout is reached, stage_done SHALL win and there SHALL be no error.
- REQ-031 start held high SHALL begin the next frame after IDLE has been present for at least one cycle; back-to-back frames SHALL be allowed.
- REQ-032 start and PS_BRAM_busy SHALL be ignored while busy=1.

Reset
- REQ-033 On rst=1 at a clk edge: State=RESET, stage_start=0, busy=0, frame_done=0, human_detected=0, timeout_err=0, and both counters cleared.
- REQ-034 rst mid-frame SHALL abort the frame without a frame_done or timeout_err pulse; rst SHALL take priority over every other input.

Verification
- REQ-035 Release rst, then start=1, PS_BRAM_busy=0, GUARD_CYCLES=4, stage_done 3 cycles after each stage_start -> State walks 2..12 then 1; 11 stage_start pulses; one frame_done.
- REQ-036 start=1 with PS_BRAM_busy=1 for 10 cycles, then 0 -> State stays 1 throughout the busy period and becomes 2 one cycle after the release.
- REQ-037 judge_result=1 at JUDGE done -> human_detected=1; next frame with judge_result=0 -> human_detected=0 only at that frame's frame_done.
- REQ-038 TIMEOUT_CYCLES=16 and no stage_done in CONV2_1 -> timeout_err pulses 16 cycles after stage_start; State=1; human_detected unchanged.
- REQ-039 stage_done pulsed during the guard window of AVG_POOL1 -> ignored; State remains 4 until the post-start stage_done.
- REQ-040 rst asserted in CONV3_2 -> next cycle State=0 with all outputs 0; the cycle after, State=1.

Source files
------------

// File: rtl/layer_sequencer.sv
// ============================================================================
// Module  : layer_sequencer
// Brief   : Frame-level sequencer stepping the CNN through its compute stages
//           with guard delay, stage handshake and per-stage timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module layer_sequencer #(
    parameter int STATE_DATAWIDTH = 4,
    parameter int RESET           = 0,
    parameter int IDLE            = 1,
    parameter int CONV1_1_STATE   = 2,
    parameter int CONV1_2_STATE   = 3,
    parameter int AVG_POOL1       = 4,
    parameter int CONV2_1_STATE   = 5,
    parameter int CONV2_2_STATE   = 6,
    parameter int AVG_POOL2       = 7,
    parameter int CONV3_1_STATE   = 8,
    parameter int CONV3_2_STATE   = 9,
    parameter int AVG_POOL3       = 10,
    parameter int FC_STATE        = 11,
    parameter int JUDGE           = 12,
    parameter int GUARD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES  = 1048575
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       PS_BRAM_busy,
    input  logic                       stage_done,
    input  logic                       judge_result,
    output logic [STATE_DATAWIDTH-1:0] State,
    output logic                       stage_start,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       human_detected,
    output logic                       timeout_err
);

    typedef enum logic [STATE_DATAWIDTH-1:0] {
        ST_RESET   = STATE_DATAWIDTH'(RESET),
        ST_IDLE    = STATE_DATAWIDTH'(IDLE),
        ST_CONV1_1 = STATE_DATAWIDTH'(CONV1_1_STATE),
        ST_CONV1_2 = STATE_DATAWIDTH'(CONV1_2_STATE),
        ST_POOL1   = STATE_DATAWIDTH'(AVG_POOL1),
        ST_CONV2_1 = STATE_DATAWIDTH'(CONV2_1_STATE),
        ST_CONV2_2 = STATE_DATAWIDTH'(CONV2_2_STATE),
        ST_POOL2   = STATE_DATAWIDTH'(AVG_POOL2),
        ST_CONV3_1 = STATE_DATAWIDTH'(CONV3_1_STATE),
        ST_CONV3_2 = STATE_DATAWIDTH'(CONV3_2_STATE),
        ST_POOL3   = STATE_DATAWIDTH'(AVG_POOL3),
        ST_FC      = STATE_DATAWIDTH'(FC_STATE),
        ST_JUDGE   = STATE_DATAWIDTH'(JUDGE)
    } state_t;

    localparam int              c_gw             = (GUARD_CYCLES > 2) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [c_gw-1:0] c_guard_load     = (GUARD_CYCLES > 0) ? c_gw'(GUARD_CYCLES - 1) : '0;
    localparam logic [19:0]     c_tmo_last       = (TIMEOUT_CYCLES > 0) ? 20'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic            c_start_on_entry = (GUARD_CYCLES == 0);

    state_t            r_state,  w_state_nxt;
    logic [c_gw-1:0]   r_guard,  w_guard_nxt;
    logic              r_started, w_started_nxt;
    logic [19:0]       r_tmo,    w_tmo_nxt;
    logic              r_stage_start, w_stage_start_nxt;
    logic              r_busy,   w_busy_nxt;
    logic              r_frame_done, w_frame_done_nxt;
    logic              r_human,  w_human_nxt;
    logic              r_timeout, w_timeout_nxt;
    logic              w_enter;
    state_t            w_enter_state;

    function automatic state_t next_stage(input state_t s);
        case (s)
            ST_CONV1_1: next_stage = ST_CONV1_2;
            ST_CONV1_2: next_stage = ST_POOL1;
            ST_POOL1:   next_stage = ST_CONV2_1;
            ST_CONV2_1: next_stage = ST_CONV2_2;
            ST_CONV2_2: next_stage = ST_POOL2;
            ST_POOL2:   next_stage = ST_CONV3_1;
            ST_CONV3_1: next_stage = ST_CONV3_2;
            ST_CONV3_2: next_stage = ST_POOL3;
            ST_POOL3:   next_stage = ST_FC;
            ST_FC:      next_stage = ST_JUDGE;
            default:    next_stage = ST_IDLE;
        endcase
    endfunction

    always_comb begin
        w_state_nxt       = r_state;
        w_guard_nxt       = r_guard;
        w_started_nxt     = r_started;
        w_tmo_nxt         = r_tmo;
        w_stage_start_nxt = 1'b0;
        w_frame_done_nxt  = 1'b0;
        w_timeout_nxt     = 1'b0;
        w_human_nxt       = r_human;
        w_enter           = 1'b0;
        w_enter_state     = ST_IDLE;

        case (r_state)
            ST_RESET: begin
                w_state_nxt   = ST_IDLE;
                w_started_nxt = 1'b0;
            end
            ST_IDLE: begin
                if (start && !PS_BRAM_busy) begin
                    w_enter       = 1'b1;
                    w_enter_state = ST_CONV1_1;
                end
            end
            ST_CONV1_1, ST_CONV1_2, ST_POOL1, ST_CONV2_1, ST_CONV2_2, ST_POOL2,
            ST_CONV3_1, ST_CONV3_2, ST_POOL3, ST_FC, ST_JUDGE: begin
                if (!r_started) begin
                    // Guard window: stage_done is deliberately not looked at here.
                    if (r_guard == '0) begin
                        w_stage_start_nxt = 1'b1;
                        w_started_nxt     = 1'b1;
                        w_tmo_nxt         = '0;
                    end else begin
                        w_guard_nxt = r_guard - c_gw'(1);
                    end
                end else if (stage_done) begin
                    if (r_state == ST_JUDGE) begin
                        w_state_nxt      = ST_IDLE;
                        w_human_nxt      = judge_result;
                        w_frame_done_nxt = 1'b1;
                        w_started_nxt    = 1'b0;
                    end else begin
                        w_enter       = 1'b1;
                        w_enter_state = next_stage(r_state);
                    end
                end else if (r_tmo == c_tmo_last) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                    w_started_nxt = 1'b0;
                    w_tmo_nxt     = '0;
                end else begin
                    w_tmo_nxt = r_tmo + 20'd1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_started_nxt = 1'b0;
            end
        endcase

        // A zero guard launches the stage on the very edge that enters it.
        if (w_enter) begin
            w_state_nxt       = w_enter_state;
            w_guard_nxt       = c_guard_load;
            w_started_nxt     = c_start_on_entry;
            w_stage_start_nxt = c_start_on_entry;
            w_tmo_nxt         = '0;
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_RESET);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RESET;
            r_guard       <= '0;
            r_started     <= 1'b0;
            r_tmo         <= '0;
            r_stage_start <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_human       <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_guard       <= w_guard_nxt;
            r_started     <= w_started_nxt;
            r_tmo         <= w_tmo_nxt;
            r_stage_start <= w_stage_start_nxt;
            r_busy        <= w_busy_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_human       <= w_human_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    assign State          = r_state;
    assign stage_start    = r_stage_start;
    assign busy           = r_busy;
    assign frame_done     = r_frame_done;
    assign human_detected = r_human;
    assign timeout_err    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// ============================================================================
// Module  : tb_layer_sequencer
// Brief   : Directed bench for layer_sequencer with a cycle-age reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_layer_sequencer;

    localparam int G = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst, start, PS_BRAM_busy, stage_done, judge_result;
    logic [3:0] State;
    logic       stage_start, busy, frame_done, human_detected, timeout_err;

    always #5 clk = ~clk;

    layer_sequencer #(
        .STATE_DATAWIDTH(4),
        .GUARD_CYCLES   (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .PS_BRAM_busy  (PS_BRAM_busy),
        .stage_done    (stage_done),
        .judge_result  (judge_result),
        .State         (State),
        .stage_start   (stage_start),
        .busy          (busy),
        .frame_done    (frame_done),
        .human_detected(human_detected),
        .timeout_err   (timeout_err)
    );

    int total = 0;
    int bad   = 0;
    int n_ss  = 0;
    int n_fd  = 0;

    // Reference: state number plus the age (cycles since entering the state).
    int m_state = 0;
    int m_age   = 0;
    bit m_ss = 0, m_fd = 0, m_te = 0, m_hd = 0, m_valid = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic enter(input int n);
        m_state = n;
        m_age   = 0;
        m_ss    = (G == 0);
    endtask

    task automatic model_step();
        if (rst) begin
            m_state = 0; m_age = 0;
            m_ss = 0; m_fd = 0; m_te = 0; m_hd = 0;
            m_valid = 1;
        end else if (m_valid) begin
            m_ss = 0; m_fd = 0; m_te = 0;
            if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                if (start && !PS_BRAM_busy) enter(2);
            end else begin
                if (m_age >= G && stage_done) begin
                    if (m_state == 12) begin
                        m_state = 1;
                        m_hd    = judge_result;
                        m_fd    = 1;
                    end else begin
                        enter(m_state + 1);
                    end
                end else if (m_age == G + T - 1) begin
                    m_te    = 1;
                    m_state = 1;
                end else begin
                    m_age++;
                    if (m_age == G) m_ss = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("state",          int'(State),    m_state);
                check("stage_start",    stage_start,    m_ss);
                check("busy",           busy,           (m_state > 1));
                check("frame_done",     frame_done,     m_fd);
                check("human_detected", human_detected, m_hd);
                check("timeout_err",    timeout_err,    m_te);
                n_ss += int'(stage_start);
                n_fd += int'(frame_done);
            end
        end
    end

    task automatic wait_start(output bit ok, output int st);
        ok = 0;
        st = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (stage_start) begin
                ok = 1;
                st = int'(State);
                break;
            end
        end
        if (!ok) check("wait_start_bound", 0, 1);
    endtask

    task automatic do_stage(input int gap, output int st);
        bit ok;
        wait_start(ok, st);
        if (ok) begin
            repeat (gap) tick();
            stage_done = 1'b1;
            tick();
            stage_done = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit allidle;
        int st;
        int cnt;

        rst = 1'b1; start = 1'b0; PS_BRAM_busy = 1'b0;
        stage_done = 1'b0; judge_result = 1'b0;
        tick();
        tick();
        check("rst_state", int'(State), 0);
        check("rst_busy", busy, 0);
        check("rst_hd", human_detected, 0);
        rst = 1'b0;
        tick();
        check("reset_to_idle", int'(State), 1);

        // Full frame, guard 4, done three cycles after each launch.
        start = 1'b1;
        judge_result = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i == 10) start = 1'b0;
            do_stage(3, st);
            check("walk_state", st, i + 2);
        end
        check("frame1_idle", int'(State), 1);
        check("frame1_done", frame_done, 1);
        check("frame1_hd", human_detected, 1);
        tick();
        check("frame1_starts", n_ss, 11);
        check("frame1_frames", n_fd, 1);

        // Input BRAM still busy: hold in IDLE, launch one cycle after release.
        start = 1'b1;
        PS_BRAM_busy = 1'b1;
        allidle = 1'b1;
        repeat (10) begin
            tick();
            if (State != 4'd1) allidle = 1'b0;
        end
        check("bram_busy_hold", allidle, 1);
        PS_BRAM_busy = 1'b0;
        tick();
        check("bram_release", int'(State), 2);
        judge_result = 1'b0;
        do_stage(3, st);
        do_stage(3, st);
        stage_done = 1'b1;
        tick();
        stage_done = 1'b0;
        check("guard_done_ignored", int'(State), 4);
        do_stage(3, st);
        check("pool1_launch_state", st, 4);
        check("pool1_advance", int'(State), 5);
        for (int i = 0; i < 7; i++) do_stage(3, st);
        start = 1'b0;
        check("hd_held_before_judge", human_detected, 1);
        do_stage(3, st);
        check("frame2_hd", human_detected, 0);
        check("frame2_done", frame_done, 1);

        // Done coinciding with the timeout limit wins.
        tick();
        start = 1'b1;
        do_stage(T - 1, st);
        check("done_at_limit_state", int'(State), 3);
        check("done_at_limit_err", timeout_err, 0);
        do_stage(3, st);
        do_stage(3, st);
        start = 1'b0;
        wait_start(ok, st);
        check("conv2_1_launch", st, 5);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cnt++;
            if (timeout_err) break;
        end
        check("timeout_latency", cnt, 16);
        check("timeout_state", int'(State), 1);
        check("timeout_hd", human_detected, 0);

        // Reset in CONV3_2 aborts the frame.
        tick();
        start = 1'b1;
        for (int i = 0; i < 7; i++) do_stage(3, st);
        check("pre_abort_state", int'(State), 9);
        rst = 1'b1;
        start = 1'b0;
        tick();
        check("abort_state", int'(State), 0);
        check("abort_busy", busy, 0);
        check("abort_start", stage_start, 0);
        check("abort_fd", frame_done, 0);
        check("abort_err", timeout_err, 0);
        rst = 1'b0;
        tick();
        check("abort_idle", int'(State), 1);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
